// File: rtl/bf16_pkg.sv
// Shared bfloat16 definitions for the multiplier/arbiter slice.
//   BF16_EXP_BIAS : exponent bias (127)
//   BF16_EXP_MAX  : largest finite biased exponent (254)
//   bf16_t        : packed {sign, exp[7:0], man[6:0]} view of a bfloat16 word
package bf16_pkg;

  localparam int unsigned BF16_EXP_BIAS = 127;
  localparam int unsigned BF16_EXP_MAX  = 254;

  typedef struct packed {
    logic       sign;
    logic [7:0] exp;
    logic [6:0] man;
  } bf16_t;

endpackage

// File: rtl/bf16_mul_pipe.sv
// bfloat16 multiplier pipeline with id/valid sideband.
// The product is formed combinationally on the input side and then carried
// through MUL_LAT register stages; stall freezes every stage at once.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   stall                 : hold all stages (data, ovf, id, valid)
//   in_valid/in_a/in_b    : operand pair entering stage 0
//   in_id                 : requester index travelling with the operands
//   out_valid/out_data    : last-stage valid and bfloat16 product
//   out_ovf/out_id        : last-stage overflow/underflow flag and requester index
module bf16_mul_pipe
  import bf16_pkg::*;
#(
  parameter int unsigned MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        in_valid,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  input  logic [2:0]  in_id,
  output logic        out_valid,
  output logic [15:0] out_data,
  output logic        out_ovf,
  output logic [2:0]  out_id
);

  bf16_t       a, b;
  logic [9:0]  exp_sum;
  logic [9:0]  exp_n;
  logic [15:0] man_prod;
  logic [6:0]  man_n;
  logic [15:0] res_data;
  logic        res_ovf;

  always_comb begin
    a        = bf16_t'(in_a);
    b        = bf16_t'(in_b);
    exp_sum  = 10'(a.exp) + 10'(b.exp) - 10'(BF16_EXP_BIAS);
    man_prod = 16'({1'b1, a.man}) * 16'({1'b1, b.man});
    // Product of two 1.x values lies in [1,4); a set MSB means renormalise by one.
    if (man_prod[15]) begin
      man_n = man_prod[14:8];
      exp_n = exp_sum + 10'd1;
    end else begin
      man_n = man_prod[13:7];
      exp_n = exp_sum;
    end
    res_data = {a.sign ^ b.sign, exp_n[7:0], man_n};
    res_ovf  = 1'b0;
    if (a.exp == 8'd0 || b.exp == 8'd0) begin
      // Zeros and denormals flush to a signed zero.
      res_data = {a.sign ^ b.sign, 15'b0};
    end else if (a.exp == 8'hff || b.exp == 8'hff || exp_n[9] || exp_n == 10'd0 ||
                 exp_n[8:0] > 9'(BF16_EXP_MAX)) begin
      // exp_n is two's complement: bit 9 set means the result underflowed below 1.
      res_data = 16'h0000;
      res_ovf  = 1'b1;
    end
  end

  logic [MUL_LAT-1:0]        vld_q;
  logic [MUL_LAT-1:0]        ovf_q;
  logic [MUL_LAT-1:0][15:0]  data_q;
  logic [MUL_LAT-1:0][2:0]   id_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      ovf_q  <= '0;
      data_q <= '0;
      id_q   <= '0;
    end else if (!stall) begin
      vld_q[0]  <= in_valid;
      ovf_q[0]  <= res_ovf;
      data_q[0] <= res_data;
      id_q[0]   <= in_id;
      for (int i = 1; i < MUL_LAT; i++) begin
        vld_q[i]  <= vld_q[i-1];
        ovf_q[i]  <= ovf_q[i-1];
        data_q[i] <= data_q[i-1];
        id_q[i]   <= id_q[i-1];
      end
    end
  end

  assign out_valid = vld_q[MUL_LAT-1];
  assign out_data  = data_q[MUL_LAT-1];
  assign out_ovf   = ovf_q[MUL_LAT-1];
  assign out_id    = id_q[MUL_LAT-1];

endmodule

// File: rtl/bf16_mul_arbiter.sv
// Round-robin arbiter feeding a shared bfloat16 multiplier pipeline.
// Optional feature macro: BF16_MUL_ARB_PERF_EN adds perf_issue/perf_stall counters.
// Ports:
//   clk, rst_n             : clock, asynchronous active-low reset
//   req_valid/req_a/req_b  : per-requester operands, requester i at bits [16i+15:16i]
//   req_ready              : per-requester accept, at most one bit high
//   rsp_valid/rsp_data     : result valid and bfloat16 product
//   rsp_ovf/rsp_id         : overflow/underflow flag and issuing requester index
//   rsp_ready              : downstream accept
//   perf_issue/perf_stall  : accept and stall-cycle counters (macro builds only)
module bf16_mul_arbiter
  import bf16_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned MUL_LAT = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [16*NUM_REQ-1:0]  req_a,
  input  logic [16*NUM_REQ-1:0]  req_b,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   rsp_valid,
  output logic [15:0]            rsp_data,
  output logic                   rsp_ovf,
  output logic [2:0]             rsp_id,
`ifdef BF16_MUL_ARB_PERF_EN
  output logic [31:0]            perf_issue,
  output logic [31:0]            perf_stall,
`endif
  input  logic                   rsp_ready
);

  logic [2:0]         ptr_q, ptr_d;
  logic [NUM_REQ-1:0] grant;
  logic [2:0]         winner;
  logic               found;
  logic               stall;
  logic               accept;
  logic [15:0]        sel_a, sel_b;

  assign stall = rsp_valid & ~rsp_ready;

  // Scan from ptr upward with wrap; the first valid requester wins.
  always_comb begin
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        if (!found && req_valid[i] && ((int'(ptr_q) + k) % int'(NUM_REQ)) == i) begin
          found    = 1'b1;
          grant[i] = 1'b1;
          winner   = 3'(i);
        end
      end
    end
  end

  assign req_ready = (rst_n && !stall) ? grant : '0;
  assign accept    = |(req_valid & req_ready);

  // grant is one-hot, so an OR-mux selects the winning operands.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (grant[i]) begin
        sel_a = sel_a | req_a[16*i +: 16];
        sel_b = sel_b | req_b[16*i +: 16];
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = (winner == 3'(NUM_REQ - 1)) ? 3'd0 : winner + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  bf16_mul_pipe #(
    .MUL_LAT (MUL_LAT)
  ) u_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .stall     (stall),
    .in_valid  (accept),
    .in_a      (sel_a),
    .in_b      (sel_b),
    .in_id     (winner),
    .out_valid (rsp_valid),
    .out_data  (rsp_data),
    .out_ovf   (rsp_ovf),
    .out_id    (rsp_id)
  );

`ifdef BF16_MUL_ARB_PERF_EN
  logic [31:0] issue_q, stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      issue_q     <= issue_q + 32'(accept);
      stall_cnt_q <= stall_cnt_q + 32'(stall);
    end
  end

  assign perf_issue = issue_q;
  assign perf_stall = stall_cnt_q;
`endif

endmodule

// File: tb/tb_bf16_mul_arbiter.sv
// Directed bench for bf16_mul_arbiter: scoreboard of expected products pushed on
// each modelled accept and compared whenever the DUT presents a result.
module tb_bf16_mul_arbiter;

  localparam int NREQ = 4;
  localparam int LAT  = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  req_valid;
  logic [63:0] req_a, req_b;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_ovf;
  logic [2:0]  rsp_id;
  logic        rsp_ready;
`ifdef BF16_MUL_ARB_PERF_EN
  logic [31:0] perf_issue, perf_stall;
`endif

  bf16_mul_arbiter #(
    .NUM_REQ (NREQ),
    .MUL_LAT (LAT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_ovf    (rsp_ovf),
    .rsp_id     (rsp_id),
`ifdef BF16_MUL_ARB_PERF_EN
    .perf_issue (perf_issue),
    .perf_stall (perf_stall),
`endif
    .rsp_ready  (rsp_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic [15:0] data;
    logic        ovf;
    logic [2:0]  id;
    int          stamp;
  } ent_t;

  ent_t        sb[$];
  int          grant_log[$];
  int          rsp_log[$];
  int          total = 0;
  int          bad = 0;
  int          mptr = 0;
  int          cyc = 0;
  int          stall_total = 0;
  int          n_rsp = 0;
  int          n_acc = 0;
  logic [15:0] last_data;
  logic        last_ovf;
  logic [2:0]  last_id;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference bf16 product, returns {ovf, data}.
  function automatic logic [16:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
    int   ea, eb, e, m, man;
    logic s;
    s  = a[15] ^ b[15];
    ea = int'(a[14:7]);
    eb = int'(b[14:7]);
    if (ea == 0 || eb == 0) return {1'b0, s, 15'b0};
    m = (128 + int'(a[6:0])) * (128 + int'(b[6:0]));
    if (m >= 32768) begin
      e   = ea + eb - 126;
      man = (m >> 8) & 127;
    end else begin
      e   = ea + eb - 127;
      man = (m >> 7) & 127;
    end
    if (ea == 255 || eb == 255 || e > 254 || e < 1) return {1'b1, 16'h0000};
    return {1'b0, s, 8'(e), 7'(man)};
  endfunction

  function automatic int rr_pick(input int p, input logic [3:0] v);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  // Mid-cycle checks plus model update for the coming clock edge.
  task automatic monitor();
    bit          stall;
    int          pick;
    logic [3:0]  exp_ready;
    logic [16:0] r;
    ent_t        e;
    if (!rst_n) begin
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_rsp_data", 32'(rsp_data), 0);
      chk("rst_rsp_ovf", 32'(rsp_ovf), 0);
      chk("rst_rsp_id", 32'(rsp_id), 0);
      chk("rst_req_ready", 32'(req_ready), 0);
      sb.delete();
      mptr = 0;
    end else begin
      stall     = rsp_valid && !rsp_ready;
      pick      = rr_pick(mptr, req_valid);
      exp_ready = (stall || pick < 0) ? 4'b0 : 4'(1 << pick);
      chk("req_ready", 32'(req_ready), 32'(exp_ready));
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          chk("rsp_valid_unexpected", 32'(rsp_valid), 0);
        end else begin
          e = sb[0];
          chk("rsp_data", 32'(rsp_data), 32'(e.data));
          chk("rsp_ovf", 32'(rsp_ovf), 32'(e.ovf));
          chk("rsp_id", 32'(rsp_id), 32'(e.id));
          if (rsp_ready) begin
            chk("rsp_latency", 32'(cyc - stall_total), 32'(e.stamp + LAT));
            void'(sb.pop_front());
            last_data = rsp_data;
            last_ovf  = rsp_ovf;
            last_id   = rsp_id;
            rsp_log.push_back(int'(rsp_id));
            n_rsp++;
          end
        end
      end
      if (!stall && pick >= 0) begin
        r       = ref_mul(req_a[16*pick +: 16], req_b[16*pick +: 16]);
        e.data  = r[15:0];
        e.ovf   = r[16];
        e.id    = 3'(pick);
        e.stamp = cyc - stall_total;
        sb.push_back(e);
        grant_log.push_back(pick);
        mptr = (pick + 1) % NREQ;
        n_acc++;
      end
      if (stall) stall_total++;
    end
    cyc++;
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b);
    req_valid[i]       = 1'b1;
    req_a[16*i +: 16]  = a;
    req_b[16*i +: 16]  = b;
  endtask

  task automatic wait_rsp(input string tag);
    int start;
    int n;
    start = n_rsp;
    n = 0;
    while (n_rsp == start && n < 20) begin
      step();
      n++;
    end
    chk(tag, 32'(n_rsp != start), 1);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      step();
      n++;
    end
    chk(tag, 32'(sb.size()), 0);
  endtask

  // Issue one operand pair on requester i and wait for its result.
  task automatic one_op(input string tag, input int i, input logic [15:0] a,
                        input logic [15:0] b);
    set_req(i, a, b);
    step();
    req_valid = '0;
    wait_rsp(tag);
  endtask

  int gexp[6] = '{0, 1, 2, 3, 0, 1};
  int r0, a0, s0;

  initial begin
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Unity product on requester 0.
    one_op("wait_one", 0, 16'h3F80, 16'h3F80);
    chk("one_data", 32'(last_data), 32'h3F80);
    chk("one_ovf", 32'(last_ovf), 0);
    chk("one_id", 32'(last_id), 0);

    // 2.0 * 3.0 and -2.0 * 3.0 on requester 2.
    one_op("wait_six", 2, 16'h4000, 16'h4040);
    chk("six_data", 32'(last_data), 32'h40C0);
    chk("six_ovf", 32'(last_ovf), 0);
    chk("six_id", 32'(last_id), 2);
    one_op("wait_nsix", 2, 16'hC000, 16'h4040);
    chk("nsix_data", 32'(last_data), 32'hC0C0);

    // Exponent overflow, zero flush, infinity input, underflow.
    one_op("wait_ovf", 1, 16'h7F00, 16'h7F00);
    chk("ovf_data", 32'(last_data), 0);
    chk("ovf_flag", 32'(last_ovf), 1);
    one_op("wait_zero", 3, 16'h0000, 16'h4000);
    chk("zero_data", 32'(last_data), 0);
    chk("zero_ovf", 32'(last_ovf), 0);
    one_op("wait_inf", 3, 16'h7F80, 16'h3F80);
    chk("inf_ovf", 32'(last_ovf), 1);
    one_op("wait_unf", 3, 16'h0080, 16'h0080);
    chk("unf_data", 32'(last_data), 0);
    chk("unf_ovf", 32'(last_ovf), 1);

    // All requesters valid with ptr back at 0: back-to-back round robin.
    grant_log.delete();
    rsp_log.delete();
    for (int i = 0; i < NREQ; i++) set_req(i, 16'h4000 + 16'(i * 16), 16'h3FC0);
    repeat (6) step();
    req_valid = '0;
    drain("rr_drain");
    chk("rr_accepts", 32'(grant_log.size()), 6);
    chk("rr_rsps", 32'(rsp_log.size()), 6);
    for (int k = 0; k < 6; k++) begin
      if (k < grant_log.size()) chk($sformatf("rr_grant_%0d", k), 32'(grant_log[k]), 32'(gexp[k]));
      if (k < rsp_log.size()) chk($sformatf("rr_rspid_%0d", k), 32'(rsp_log[k]), 32'(gexp[k]));
    end

    // Downstream backpressure for five cycles with the pipeline full.
    r0 = n_rsp;
    a0 = n_acc;
    s0 = stall_total;
    for (int i = 0; i < NREQ; i++) set_req(i, 16'h3F80 + 16'(i * 32), 16'hC100);
    repeat (3) step();
    rsp_ready = 1'b0;
    repeat (5) step();
    rsp_ready = 1'b1;
    req_valid = '0;
    drain("stall_drain");
    chk("stall_cycles", 32'(stall_total - s0), 5);
    chk("stall_no_loss", 32'(n_rsp - r0), 32'(n_acc - a0));

    // Reset with two operations in flight.
    set_req(1, 16'h4000, 16'h4000);
    set_req(2, 16'h4040, 16'h4040);
    repeat (2) step();
    chk("pre_rst_valid", 32'(rsp_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("async_rsp_valid", 32'(rsp_valid), 0);
    chk("async_req_ready", 32'(req_ready), 0);
    repeat (2) step();
    rst_n = 1'b1;
    req_valid = '0;
    repeat (4) step();
    grant_log.delete();
    for (int i = 0; i < NREQ; i++) set_req(i, 16'h3F80, 16'h4000);
    step();
    req_valid = '0;
    wait_rsp("post_rst_wait");
    chk("post_rst_grants", 32'(grant_log.size()), 1);
    if (grant_log.size() > 0) chk("post_rst_grant0", 32'(grant_log[0]), 0);
    chk("post_rst_id", 32'(last_id), 0);
    chk("post_rst_data", 32'(last_data), 32'h4000);
    repeat (4) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
